icb_imu_param: RTL and testbench



---
 rtl/icb_imu_pkg.sv | 14 +
 rtl/icb_imu_wmerge.sv | 68 ++++++
 rtl/icb_imu_param.sv | 173 +++++++++++++++++
 tb/tb_icb_imu_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_imu_pkg.sv
// Shared types and constants for the ICB interface unit of the MHSA accelerator.
package icb_imu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_STATUS = 1;
  localparam int CSR_GP0    = 2;

endpackage

// File: rtl/icb_imu_wmerge.sv
// Merges 32-bit lane writes into one usram line and issues the line write
// when the last lane of the line arrives.
module icb_imu_wmerge
  import icb_imu_pkg::*;
#(
  parameter int SRAM_DW = 64,
  parameter int SRAM_AW = 14,
  localparam int LANES  = SRAM_DW / 32,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [SRAM_AW-1:0]   line,
  input  logic [LANE_W-1:0]    lane,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wmask,
  output logic [SRAM_DW-1:0]   usram_wdata,
  output logic [SRAM_DW/8-1:0] usram_be,
  output logic                 usram_we
);

  logic [SRAM_DW-1:0]   buf_q, buf_d;
  logic [SRAM_DW/8-1:0] be_q, be_d;
  logic [SRAM_AW-1:0]   line_q;
  logic                 we_q;
  logic                 last_lane;

  assign last_lane = (lane == LANE_W'(LANES - 1));

  // A pending partial for a different line is dropped silently; the new
  // lane starts a fresh accumulation.
  always_comb begin
    buf_d = buf_q;
    be_d  = (we_q || ((be_q != '0) && (line != line_q))) ? '0 : be_q;
    for (int k = 0; k < LANES; k++) begin
      for (int b = 0; b < 4; b++) begin
        if ((lane == LANE_W'(k)) && wmask[b]) begin
          buf_d[32*k + 8*b +: 8] = wdata[8*b +: 8];
          be_d[4*k + b]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q  <= '0;
      be_q   <= '0;
      line_q <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= wr_en && last_lane;
      if (wr_en) begin
        buf_q  <= buf_d;
        be_q   <= be_d;
        line_q <= line;
      end else if (we_q) begin
        be_q <= '0;
      end
    end
  end

  assign usram_wdata = buf_q;
  assign usram_be    = be_q;
  assign usram_we    = we_q;

endmodule

// File: rtl/icb_imu_param.sv
// ICB slave decoding a CSR window and a wide usram window; reads are
// sequenced through RD_WAIT to absorb the one-cycle usram read latency.
module icb_imu_param
  import icb_imu_pkg::*;
#(
  parameter int          SRAM_DW   = 64,
  parameter int          SRAM_AW   = 14,
  parameter logic [31:0] SRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] CSR_BASE  = 32'h0007_0000,
  parameter int          NUM_CSR   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        icb_cmd_valid,
  output logic                        icb_cmd_ready,
  input  logic                        icb_cmd_read,
  input  logic [31:0]                 icb_cmd_addr,
  input  logic [31:0]                 icb_cmd_wdata,
  input  logic [3:0]                  icb_cmd_wmask,
  output logic                        icb_rsp_valid,
  input  logic                        icb_rsp_ready,
  output logic [31:0]                 icb_rsp_rdata,
  output logic                        icb_rsp_err,
  output logic                        start_o,
  input  logic                        done_i,
  input  logic                        busy_i,
  output logic [32*(NUM_CSR-2)-1:0]   csr_o,
  output logic [SRAM_AW-1:0]          usram_addr,
  output logic [SRAM_DW-1:0]          usram_wdata,
  output logic [SRAM_DW/8-1:0]        usram_be,
  output logic                        usram_we,
  output logic                        usram_re,
  input  logic [SRAM_DW-1:0]          usram_rdata
);

  localparam int          LANES      = SRAM_DW / 32;
  localparam int          LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int          BYTE_SH    = $clog2(SRAM_DW / 8);
  localparam int          NUM_GP     = NUM_CSR - 2;
  localparam logic [63:0] SRAM_BYTES = 64'(SRAM_DW / 8) << SRAM_AW;
  localparam logic [31:0] CSR_BYTES  = 32'(NUM_CSR * 4);

  state_t              state_q, state_d;
  logic                accept, in_csr, in_usram;
  logic                usram_rd, usram_wr, csr_wr;
  logic [31:0]         usram_off, csr_off;
  logic [3:0]          csr_idx;
  logic [SRAM_AW-1:0]  line, addr_q;
  logic [LANE_W-1:0]   lane, lane_q;
  logic [31:0]         rdata_q, csr_rdata, lane_word;
  logic                err_q, done_q, start_q;
  logic [31:0]         gp_q [NUM_GP];

  // Offsets below a window base wrap to large values and fall out of range.
  assign usram_off = icb_cmd_addr - SRAM_BASE;
  assign csr_off   = icb_cmd_addr - CSR_BASE;
  assign in_csr    = (csr_off < CSR_BYTES);
  assign in_usram  = !in_csr && ({32'd0, usram_off} < SRAM_BYTES);
  assign csr_idx   = csr_off[5:2];
  assign line      = usram_off[BYTE_SH +: SRAM_AW];
  assign lane      = (LANES > 1) ? icb_cmd_addr[2 +: LANE_W] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        icb_cmd_ready = 1'b1;
        accept        = icb_cmd_valid && rst_n;
        if (accept) state_d = (icb_cmd_read && in_usram) ? RD_WAIT : RSP;
      end
      RD_WAIT: state_d = RSP;
      RSP: begin
        icb_rsp_valid = 1'b1;
        if (icb_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign usram_rd   = accept && icb_cmd_read && in_usram;
  assign usram_wr   = accept && !icb_cmd_read && in_usram;
  assign csr_wr     = accept && !icb_cmd_read && in_csr;
  assign usram_re   = usram_rd;
  assign usram_addr = usram_rd ? line : addr_q;

  always_comb begin
    csr_rdata = '0;
    if (csr_idx == 4'(CSR_STATUS)) csr_rdata = {30'd0, busy_i, done_q};
    for (int i = 0; i < NUM_GP; i++) begin
      if (csr_idx == 4'(CSR_GP0 + i)) csr_rdata = gp_q[i];
    end
  end

  always_comb begin
    lane_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) lane_word = usram_rdata[32*k +: 32];
    end
  end

  // Response fields are loaded at accept (or at the end of RD_WAIT) and
  // then held untouched for as long as the master stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      lane_q  <= '0;
      addr_q  <= '0;
    end else if (accept) begin
      lane_q  <= lane;
      err_q   <= !(in_csr || in_usram);
      rdata_q <= (icb_cmd_read && in_csr) ? csr_rdata : '0;
      if (in_usram) addr_q <= line;
    end else if (state_q == RD_WAIT) begin
      rdata_q <= lane_word;
    end
  end

  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
    end else begin
      start_q <= csr_wr && (csr_idx == 4'(CSR_CTRL)) && icb_cmd_wmask[0] && icb_cmd_wdata[0];
      if (done_i)
        done_q <= 1'b1;
      else if (csr_wr && (csr_idx == 4'(CSR_STATUS)) && icb_cmd_wmask[0] && icb_cmd_wdata[0])
        done_q <= 1'b0;
      for (int i = 0; i < NUM_GP; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (csr_wr && (csr_idx == 4'(CSR_GP0 + i)) && icb_cmd_wmask[b])
            gp_q[i][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  assign start_o = start_q;

  always_comb begin
    csr_o = '0;
    for (int i = 0; i < NUM_GP; i++) csr_o[32*i +: 32] = gp_q[i];
  end

  icb_imu_wmerge #(
    .SRAM_DW (SRAM_DW),
    .SRAM_AW (SRAM_AW)
  ) u_wmerge (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (usram_wr),
    .line        (line),
    .lane        (lane),
    .wdata       (icb_cmd_wdata),
    .wmask       (icb_cmd_wmask),
    .usram_wdata (usram_wdata),
    .usram_be    (usram_be),
    .usram_we    (usram_we)
  );

endmodule

// File: tb/tb_icb_imu_param.sv
// Directed self-checking bench: a 64-bit and a 128-bit instance share one
// command stream, steered to one of them by use128.
module tb_icb_imu_param;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_read, rsp_ready, done_i, busy_i, use128;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [3:0]   cmd_wmask;

  logic         rdy64, rv64, err64, start64, we64, re64;
  logic [31:0]  rd64;
  logic [191:0] csr64;
  logic [13:0]  addr64;
  logic [63:0]  wdata64, rdata64;
  logic [7:0]   be64;

  logic         rdy128, rv128, err128, start128, we128, re128;
  logic [31:0]  rd128;
  logic [191:0] csr128;
  logic [13:0]  addr128;
  logic [127:0] wdata128;
  logic [127:0] rdata128 = '0;
  logic [15:0]  be128;

  logic         cur_ready, cur_valid, cur_err;
  logic [31:0]  cur_rdata;

  int assertions = 0;
  int failures   = 0;
  int we128_cnt = 0, we64_cnt = 0, re64_cnt = 0, start64_cnt = 0, line2_hit = 0;
  logic [127:0] last_wdata128 = '0;
  logic [15:0]  last_be128 = '0;
  logic [13:0]  last_addr128 = '0;

  logic [31:0] a_dat [4] = '{32'h0A0A_0A00, 32'h1A1A_1A11, 32'h2A2A_2A22, 32'h3A3A_3A33};
  logic [31:0] b_dat [4] = '{32'hB0B0_0B00, 32'hB1B1_1B11, 32'hB2B2_2B22, 32'hB3B3_3B33};

  always #5 clk = ~clk;

  icb_imu_param #(.SRAM_DW(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(cmd_valid && !use128), .icb_cmd_ready(rdy64),
    .icb_cmd_read(cmd_read), .icb_cmd_addr(cmd_addr),
    .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rv64), .icb_rsp_ready(rsp_ready),
    .icb_rsp_rdata(rd64), .icb_rsp_err(err64),
    .start_o(start64), .done_i(done_i), .busy_i(busy_i), .csr_o(csr64),
    .usram_addr(addr64), .usram_wdata(wdata64), .usram_be(be64),
    .usram_we(we64), .usram_re(re64), .usram_rdata(rdata64)
  );

  icb_imu_param #(.SRAM_DW(128)) dut128 (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(cmd_valid && use128), .icb_cmd_ready(rdy128),
    .icb_cmd_read(cmd_read), .icb_cmd_addr(cmd_addr),
    .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rv128), .icb_rsp_ready(rsp_ready),
    .icb_rsp_rdata(rd128), .icb_rsp_err(err128),
    .start_o(start128), .done_i(done_i), .busy_i(busy_i), .csr_o(csr128),
    .usram_addr(addr128), .usram_wdata(wdata128), .usram_be(be128),
    .usram_we(we128), .usram_re(re128), .usram_rdata(rdata128)
  );

  assign cur_ready = use128 ? rdy128 : rdy64;
  assign cur_valid = use128 ? rv128  : rv64;
  assign cur_err   = use128 ? err128 : err64;
  assign cur_rdata = use128 ? rd128  : rd64;

  // usram model: only line 3 holds known data, and data appears only the
  // cycle after a read strobe.
  always @(posedge clk) begin
    if (re64 && addr64 == 14'd3) rdata64 <= 64'h1111_2222_3333_4444;
    else                         rdata64 <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  always @(negedge clk) begin
    if (we128) begin
      we128_cnt     <= we128_cnt + 1;
      last_wdata128 <= wdata128;
      last_be128    <= be128;
      last_addr128  <= addr128;
      if (addr128 == 14'd2) line2_hit <= line2_hit + 1;
    end
    if (we64)    we64_cnt    <= we64_cnt + 1;
    if (re64)    re64_cnt    <= re64_cnt + 1;
    if (start64) start64_cnt <= start64_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full ICB transfer with rsp_ready high; call at a falling edge.
  task automatic applyStimulus(input string tag, input logic rd, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] wm,
                               input logic pulse_done, input int exp_lat,
                               input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    int lat;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    done_i = pulse_done;
    n = 0;
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    done_i = 1'b0;
    lat = 1;
    while (!cur_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_err"}, cur_err, exp_err);
    if (rd) checkOutput({tag, "_rdata"}, cur_rdata, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    logic [191:0] exp_csr;
    int we_before, re_before;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1; done_i = 1'b0;
    busy_i = 1'b0; use128 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_cmd_ready", rdy128, 1'b1);
    checkOutput("rst_rsp_valid", rv128, 1'b0);
    checkOutput("rst_rsp_err", err128, 1'b0);
    checkOutput("rst_rsp_rdata", rd128, 32'd0);
    checkOutput("rst_start", start128, 1'b0);
    checkOutput("rst_we", we128, 1'b0);
    checkOutput("rst_re", re128, 1'b0);
    checkOutput("rst_be", be128, 16'd0);
    checkOutput("rst_usram_addr", addr128, 14'd0);
    checkOutput("rst_csr_o", csr64, 192'd0);

    // Full line 5 on the 128-bit instance
    applyStimulus("w128_l0", 1'b0, 32'h50, a_dat[0], 4'hF, 1'b0, 1, 1'b0, 32'd0);
    applyStimulus("w128_l1", 1'b0, 32'h54, a_dat[1], 4'hF, 1'b0, 1, 1'b0, 32'd0);
    applyStimulus("w128_l2", 1'b0, 32'h58, a_dat[2], 4'hF, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("w128_be_partial", be128, 16'h0FFF);
    checkOutput("w128_no_we_yet", we128_cnt, 0);
    applyStimulus("w128_l3", 1'b0, 32'h5C, a_dat[3], 4'hF, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("w128_we_count", we128_cnt, 1);
    checkOutput("w128_addr", last_addr128, 14'd5);
    checkOutput("w128_wdata", last_wdata128, {a_dat[3], a_dat[2], a_dat[1], a_dat[0]});
    checkOutput("w128_be", last_be128, 16'hFFFF);
    checkOutput("w128_be_cleared", be128, 16'h0000);

    // Partial on line 2, then a full line 7
    applyStimulus("p128_l2", 1'b0, 32'h20, 32'h5555_5555, 4'h3, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("p128_be_partial", be128, 16'h0003);
    for (int k = 0; k < 4; k++)
      applyStimulus("p128_l7", 1'b0, 32'h70 + 32'(4 * k), b_dat[k], 4'hF, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("p128_we_count", we128_cnt, 2);
    checkOutput("p128_addr", last_addr128, 14'd7);
    checkOutput("p128_be", last_be128, 16'hFFFF);
    checkOutput("p128_wdata", last_wdata128, {b_dat[3], b_dat[2], b_dat[1], b_dat[0]});
    checkOutput("p128_line2_untouched", line2_hit, 0);

    // usram read on the 64-bit instance: line 3, lane 1
    use128 = 1'b0;
    re_before = re64_cnt;
    applyStimulus("r64", 1'b1, 32'h1C, 32'd0, 4'h0, 1'b0, 2, 1'b0, 32'h1111_2222);
    checkOutput("r64_re_count", re64_cnt - re_before, 1);
    checkOutput("r64_no_we", we64_cnt, 0);

    // START / STATUS
    applyStimulus("ctrl_wr", 1'b0, 32'h7_0000, 32'd1, 4'hF, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("start_single_pulse", start64_cnt, 1);
    applyStimulus("ctrl_rd", 1'b1, 32'h7_0000, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'd0);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    applyStimulus("status_done", 1'b1, 32'h7_0004, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'd1);
    busy_i = 1'b1;
    applyStimulus("status_busy", 1'b1, 32'h7_0004, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'd3);
    busy_i = 1'b0;
    applyStimulus("w1c_collide", 1'b0, 32'h7_0004, 32'd1, 4'hF, 1'b1, 1, 1'b0, 32'd0);
    applyStimulus("status_set_wins", 1'b1, 32'h7_0004, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'd1);
    applyStimulus("w1c_plain", 1'b0, 32'h7_0004, 32'd1, 4'hF, 1'b0, 1, 1'b0, 32'd0);
    applyStimulus("status_cleared", 1'b1, 32'h7_0004, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("start_still_single", start64_cnt, 1);

    // General CSRs with byte masks
    applyStimulus("gp2_wr", 1'b0, 32'h7_0008, 32'hDEAD_BEEF, 4'hF, 1'b0, 1, 1'b0, 32'd0);
    applyStimulus("gp2_wr_byte1", 1'b0, 32'h7_0008, 32'h0000_5500, 4'b0010, 1'b0, 1, 1'b0, 32'd0);
    applyStimulus("gp2_rd", 1'b1, 32'h7_0008, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'hDEAD_55EF);
    applyStimulus("gp7_wr", 1'b0, 32'h7_001C, 32'h1234_5678, 4'hF, 1'b0, 1, 1'b0, 32'd0);
    exp_csr = '0;
    exp_csr[31:0]    = 32'hDEAD_55EF;
    exp_csr[191:160] = 32'h1234_5678;
    checkOutput("csr_o_map", csr64, exp_csr);

    // Out-of-range accesses
    applyStimulus("oor_csr_rd", 1'b1, 32'h7_0020, 32'd0, 4'h0, 1'b0, 1, 1'b1, 32'd0);
    applyStimulus("oor_csr_wr", 1'b0, 32'h7_0020, 32'hFFFF_FFFF, 4'hF, 1'b0, 1, 1'b1, 32'd0);
    checkOutput("oor_csr_no_effect", csr64, exp_csr);
    re_before = re64_cnt;
    applyStimulus("oor_usram_rd", 1'b1, 32'h2_0000, 32'd0, 4'h0, 1'b0, 1, 1'b1, 32'd0);
    checkOutput("oor_usram_no_re", re64_cnt - re_before, 0);
    we_before = we64_cnt;
    applyStimulus("oor_usram_wr", 1'b0, 32'h2_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 1, 1'b1, 32'd0);
    checkOutput("oor_usram_no_we", we64_cnt - we_before, 0);

    // Leave a partial line pending on the 128-bit instance
    use128 = 1'b1;
    applyStimulus("pend128", 1'b0, 32'h94, 32'hCAFE_F00D, 4'hF, 1'b0, 1, 1'b0, 32'd0);
    checkOutput("pend128_be", be128, 16'h00F0);

    // Backpressure on the 64-bit instance
    use128 = 1'b0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h7_0008; cmd_wmask = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", rv64, 1'b1);
      checkOutput("bp_rsp_rdata", rd64, 32'hDEAD_55EF);
      checkOutput("bp_rsp_err", err64, 1'b0);
      checkOutput("bp_cmd_ready", rdy64, 1'b0);
      @(negedge clk);
    end

    // Reset while the response is still pending
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_rsp_valid", rv64, 1'b0);
    checkOutput("rstmid_cmd_ready", rdy64, 1'b1);
    checkOutput("rstmid_be128", be128, 16'h0000);
    checkOutput("rstmid_csr_o", csr64, 192'd0);
    rsp_ready = 1'b1;
    applyStimulus("post_rst_gp2", 1'b1, 32'h7_0008, 32'd0, 4'h0, 1'b0, 1, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
